// File: rtl/ame_num_scale_pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ame_num_scale_pipe_pkg - shared widths, types and MSB-index helper          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package ame_num_scale_pipe_pkg;

  localparam int C_DATA_BITS  = 64;
  localparam int C_SCALE_BITS = 44;
  localparam int C_NUM_PAIRS  = 2;
  localparam int SHIFT_BITS   = $clog2(C_DATA_BITS);

  // One extra bit holds the sum of two MSB indices.
  typedef logic [SHIFT_BITS:0] psum_t;

  function automatic logic [SHIFT_BITS-1:0] msb_idx(input logic [C_DATA_BITS-1:0] x);
    logic [C_DATA_BITS-1:0] mag;
    mag     = x[C_DATA_BITS-1] ? -x : x;
    msb_idx = '0;
    for (int i = 0; i < C_DATA_BITS; i++) begin
      if (mag[i]) msb_idx = i[SHIFT_BITS-1:0];
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/ame_num_scale_pipe_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ame_num_scale_pipe_if - input/output stream bundle of the operand scaler    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface ame_num_scale_pipe_if
  import ame_num_scale_pipe_pkg::*;
#(
  parameter int DATA_BITS = C_DATA_BITS,
  parameter int NUM_PAIRS = C_NUM_PAIRS
) ();

  localparam int N   = 2 * NUM_PAIRS;
  localparam int SHW = $clog2(DATA_BITS);

  logic                   in_valid_i;
  logic                   in_ready_o;
  logic                   round_i;
  logic [N*DATA_BITS-1:0] data_i;
  logic                   out_valid_o;
  logic                   out_ready_i;
  logic [N*DATA_BITS-1:0] data_o;
  logic [SHW-1:0]         shift_o;
  logic                   clamp_o;

  modport master (
    output in_valid_i, round_i, data_i, out_ready_i,
    input  in_ready_o, out_valid_o, data_o, shift_o, clamp_o
  );

  modport slave (
    input  in_valid_i, round_i, data_i, out_ready_i,
    output in_ready_o, out_valid_o, data_o, shift_o, clamp_o
  );

endinterface
`default_nettype wire

// File: rtl/ame_num_scale_pipe_msb_idx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ame_num_scale_pipe_msb_idx - leading-one index of |x| for a signed operand  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ame_num_scale_pipe_msb_idx
  import ame_num_scale_pipe_pkg::*;
#(
  parameter  int DATA_BITS = C_DATA_BITS,
  localparam int SHW       = $clog2(DATA_BITS)
) (
  input  logic [DATA_BITS-1:0] x_i,
  output logic [SHW-1:0]       e_o
);

  logic [DATA_BITS-1:0] w_mag;

  // The most negative value negates to itself, whose top bit gives DATA_BITS-1.
  always_comb begin
    w_mag = x_i[DATA_BITS-1] ? -x_i : x_i;
    e_o   = '0;
    for (int i = 0; i < DATA_BITS; i++) begin
      if (w_mag[i]) e_o = i[SHW-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/ame_num_scale_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ame_num_scale_pipe - 3-stage common-shift pre-scaler for signed A/B pairs   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ame_num_scale_pipe
  import ame_num_scale_pipe_pkg::*;
#(
  parameter int DATA_BITS  = C_DATA_BITS,
  parameter int SCALE_BITS = C_SCALE_BITS,
  parameter int NUM_PAIRS  = C_NUM_PAIRS
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  ame_num_scale_pipe_if.slave   bus
);

  localparam int N   = 2 * NUM_PAIRS;
  localparam int SHW = $clog2(DATA_BITS);
  localparam int W   = N * DATA_BITS;
  localparam logic [SHW:0] MAX_SHIFT = (SHW+1)'(DATA_BITS - 1);
  localparam logic [SHW:0] SCALE_W   = (SHW+1)'(SCALE_BITS);

  logic [SHW-1:0] w_e [N];

  logic           s1_valid_q, s1_round_q;
  logic [W-1:0]   s1_data_q;
  logic [SHW-1:0] s1_e_q [N];

  logic           s2_valid_q, s2_round_q, s2_clamp_q;
  logic [W-1:0]   s2_data_q;
  logic [SHW-1:0] s2_shift_q;

  logic           out_valid_q, clamp_q;
  logic [W-1:0]   data_q;
  logic [SHW-1:0] shift_q;

  logic           s1_take, s2_take, s3_take;
  logic [SHW:0]   pm_d, raw_d;
  logic [SHW-1:0] shift_d;
  logic           clamp_d;
  logic [W-1:0]   data_d;

  // A stage takes new contents when it is empty or its beat moves on.
  assign s3_take = !out_valid_q || bus.out_ready_i;
  assign s2_take = !s2_valid_q || s3_take;
  assign s1_take = !s1_valid_q || s2_take;

  assign bus.in_ready_o  = s1_take;
  assign bus.out_valid_o = out_valid_q;
  assign bus.data_o      = data_q;
  assign bus.shift_o     = shift_q;
  assign bus.clamp_o     = clamp_q;

  for (genvar k = 0; k < N; k++) begin : g_msb
    ame_num_scale_pipe_msb_idx #(.DATA_BITS(DATA_BITS)) u_msb (
      .x_i (bus.data_i[k*DATA_BITS +: DATA_BITS]),
      .e_o (w_e[k])
    );
  end

  always_comb begin
    logic [SHW:0] psum;
    psum = '0;
    pm_d = '0;
    for (int p = 0; p < NUM_PAIRS; p++) begin
      psum = {1'b0, s1_e_q[2*p+1]} + {1'b0, s1_e_q[2*p]};
      if (psum > pm_d) pm_d = psum;
    end
    raw_d   = (int'(pm_d) > SCALE_BITS) ? (pm_d - SCALE_W) : '0;
    clamp_d = (raw_d > MAX_SHIFT);
    shift_d = clamp_d ? MAX_SHIFT[SHW-1:0] : raw_d[SHW-1:0];
  end

  // One extra bit absorbs the rounding bias; half of 2^shift is zero when shift is 0.
  always_comb begin
    logic signed [DATA_BITS:0] ext, bias;
    data_d = s2_data_q;
    ext    = '0;
    bias   = s2_round_q ? (((DATA_BITS+1)'(1) << s2_shift_q) >> 1) : '0;
    for (int p = 0; p < NUM_PAIRS; p++) begin
      ext = {s2_data_q[(2*p+2)*DATA_BITS-1], s2_data_q[(2*p+1)*DATA_BITS +: DATA_BITS]};
      data_d[(2*p+1)*DATA_BITS +: DATA_BITS] = DATA_BITS'((ext + bias) >>> s2_shift_q);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid_q  <= 1'b0;
      s1_round_q  <= 1'b0;
      s1_data_q   <= '0;
      for (int k = 0; k < N; k++) s1_e_q[k] <= '0;
      s2_valid_q  <= 1'b0;
      s2_round_q  <= 1'b0;
      s2_data_q   <= '0;
      s2_shift_q  <= '0;
      s2_clamp_q  <= 1'b0;
      out_valid_q <= 1'b0;
      data_q      <= '0;
      shift_q     <= '0;
      clamp_q     <= 1'b0;
    end else if (flush_i) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      if (s3_take) begin
        out_valid_q <= s2_valid_q;
        if (s2_valid_q) begin
          data_q  <= data_d;
          shift_q <= s2_shift_q;
          clamp_q <= s2_clamp_q;
        end
      end
      if (s2_take) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_data_q  <= s1_data_q;
          s2_round_q <= s1_round_q;
          s2_shift_q <= shift_d;
          s2_clamp_q <= clamp_d;
        end
      end
      if (s1_take) begin
        s1_valid_q <= bus.in_valid_i;
        if (bus.in_valid_i) begin
          s1_data_q  <= bus.data_i;
          s1_round_q <= bus.round_i;
          for (int k = 0; k < N; k++) s1_e_q[k] <= w_e[k];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ame_num_scale_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ame_num_scale_pipe - directed and randomized checks of the pre-scaler    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_ame_num_scale_pipe;

  localparam int DB    = 64;
  localparam int NP    = 2;
  localparam int NOPS  = 2 * NP;
  localparam int W     = NOPS * DB;
  localparam int SCALE = 44;
  localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;

  typedef struct packed {
    logic [W-1:0] d;
    logic [5:0]   s;
    logic         c;
  } exp_t;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic flush = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  ame_num_scale_pipe_if #(.DATA_BITS(DB), .NUM_PAIRS(NP)) bus ();

  ame_num_scale_pipe #(.DATA_BITS(DB), .SCALE_BITS(SCALE), .NUM_PAIRS(NP)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (flush),
    .bus     (bus)
  );

  function automatic int floor_log2(input logic [63:0] m);
    logic [63:0] v;
    int e;
    v = m;
    e = 0;
    while (v > 64'd1) begin
      v = v >> 1;
      e++;
    end
    return e;
  endfunction

  // Reference: exact integer arithmetic, floor division by 2^shift.
  function automatic exp_t model(input logic [W-1:0] d, input logic rnd);
    int e [NOPS];
    int pm, r, s;
    logic [63:0] x;
    logic signed [65:0] a;
    exp_t o;
    pm = 0;
    for (int k = 0; k < NOPS; k++) begin
      x = d[k*DB +: DB];
      e[k] = floor_log2(x[63] ? -x : x);
    end
    for (int p = 0; p < NP; p++) if (e[2*p+1] + e[2*p] > pm) pm = e[2*p+1] + e[2*p];
    r = (pm > SCALE) ? pm - SCALE : 0;
    s = (r > DB - 1) ? DB - 1 : r;
    o.d = d;
    o.s = 6'(s);
    o.c = (r > DB - 1);
    for (int p = 0; p < NP; p++) begin
      x = d[(2*p+1)*DB +: DB];
      a = {{2{x[63]}}, x};
      if (rnd && s > 0) a = a + (66'sd1 <<< (s - 1));
      a = a >>> s;
      o.d[(2*p+1)*DB +: DB] = a[63:0];
    end
    return o;
  endfunction

  function automatic logic [W-1:0] pack4(input logic [63:0] m, dd, l, c);
    return {m, dd, l, c};
  endfunction

  function automatic logic [63:0] rand_op();
    logic [63:0] v;
    int w;
    v = {$urandom, $urandom};
    w = $urandom_range(0, 63);
    v = v >> (63 - w);
    if ($urandom_range(0, 1) == 1) v = -v;
    if ($urandom_range(0, 15) == 0) v = 64'h8000_0000_0000_0000;
    return v;
  endfunction

  function automatic logic [W-1:0] rand_data();
    return pack4(rand_op(), rand_op(), rand_op(), rand_op());
  endfunction

  // Offers one beat into an empty pipeline and returns the first output and its latency.
  task automatic send_one(input logic [W-1:0] d, input logic r, output exp_t obs, output int lat);
    @(negedge clk);
    bus.in_valid_i  = 1'b1;
    bus.data_i      = d;
    bus.round_i     = r;
    bus.out_ready_i = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      bus.in_valid_i = 1'b0;
      lat++;
      #1;
    end while (!bus.out_valid_o && lat < 20);
    obs = {bus.data_o, bus.shift_o, bus.clamp_o};
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    checks++;
    if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", bus.out_valid_o); end
    checks++;
    if (bus.data_o !== '0) begin errors++; $display("FAIL reset_data got=%h want=0", bus.data_o); end
    checks++;
    if (bus.shift_o !== 6'd0) begin errors++; $display("FAIL reset_shift got=%0d want=0", bus.shift_o); end
    checks++;
    if (bus.clamp_o !== 1'b0) begin errors++; $display("FAIL reset_clamp got=%b want=0", bus.clamp_o); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_threshold();
    exp_t obs;
    int lat;
    logic [W-1:0] want;
    send_one(pack4(64'd1 << 40, 64'd1 << 10, 64'd1, 64'd1), 1'b0, obs, lat);
    want = pack4(64'd1 << 34, 64'd1 << 10, 64'd0, 64'd1);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL thr_latency got=%0d want=3", lat); end
    checks++;
    if (obs.d !== want) begin errors++; $display("FAIL thr_data got=%h want=%h", obs.d, want); end
    checks++;
    if (obs.s !== 6'd6) begin errors++; $display("FAIL thr_shift got=%0d want=6", obs.s); end
    checks++;
    if (obs.c !== 1'b0) begin errors++; $display("FAIL thr_clamp got=%b want=0", obs.c); end
  endtask

  task automatic test_rounding();
    exp_t obs, want;
    int lat;
    send_one(pack4(64'd1 << 40, 64'd1 << 10, 64'd32, 64'd1), 1'b1, obs, lat);
    want = {pack4(64'd1 << 34, 64'd1 << 10, 64'd1, 64'd1), 6'd6, 1'b0};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL round_half_up got=%h want=%h", obs, want); end
    send_one(pack4(-(64'd1 << 40), 64'd1 << 10, -64'd33, 64'd1), 1'b0, obs, lat);
    want = {pack4(-(64'd1 << 34), 64'd1 << 10, -64'd1, 64'd1), 6'd6, 1'b0};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL round_sign got=%h want=%h", obs, want); end
  endtask

  task automatic test_below();
    exp_t obs, want;
    int lat;
    logic [W-1:0] d;
    d = pack4(64'd1 << 20, 64'd1 << 20, 64'd1 << 20, 64'd1 << 20);
    send_one(d, 1'b1, obs, lat);
    want = {d, 6'd0, 1'b0};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL below_thr got=%h want=%h", obs, want); end
  endtask

  task automatic test_clamp();
    exp_t obs, want;
    int lat;
    send_one(pack4(MAXP, MAXP, 64'd5, 64'd7), 1'b0, obs, lat);
    want = {pack4(64'd0, MAXP, 64'd0, 64'd7), 6'd63, 1'b1};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL clamp_trunc got=%h want=%h", obs, want); end
    send_one(pack4(MAXP, MAXP, 64'd5, 64'd7), 1'b1, obs, lat);
    want = {pack4(64'd1, MAXP, 64'd0, 64'd7), 6'd63, 1'b1};
    checks++;
    if (obs !== want) begin errors++; $display("FAIL clamp_round got=%h want=%h", obs, want); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] bd [5];
    logic         br [5];
    exp_t         ex [5];
    exp_t         held, obs;
    int           idx, got, cyc, sel;
    for (int k = 0; k < 5; k++) begin
      bd[k] = rand_data();
      br[k] = 1'($urandom_range(0, 1));
      ex[k] = model(bd[k], br[k]);
    end
    idx  = 0;
    held = '0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      sel = (idx < 5) ? idx : 4;
      bus.out_ready_i = 1'b0;
      bus.in_valid_i  = (idx < 5);
      bus.data_i      = bd[sel];
      bus.round_i     = br[sel];
      #1;
      if (c >= 3) begin
        checks++;
        if (bus.in_ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready cycle=%0d got=%b want=0", c, bus.in_ready_o); end
      end
      if (c == 3) begin
        held = {bus.data_o, bus.shift_o, bus.clamp_o};
        checks++;
        if (!bus.out_valid_o || held !== ex[0]) begin
          errors++; $display("FAIL bp_first valid=%b got=%h want=%h", bus.out_valid_o, held, ex[0]);
        end
      end
      if (c > 3) begin
        obs = {bus.data_o, bus.shift_o, bus.clamp_o};
        checks++;
        if (!bus.out_valid_o || obs !== held) begin
          errors++; $display("FAIL bp_hold valid=%b got=%h want=%h", bus.out_valid_o, obs, held);
        end
      end
      if (bus.in_valid_i && bus.in_ready_o) idx++;
    end
    checks++;
    if (idx !== 3) begin errors++; $display("FAIL bp_accepted got=%0d want=3", idx); end
    got = 0;
    cyc = 0;
    while (got < 5 && cyc < 40) begin
      @(negedge clk);
      sel = (idx < 5) ? idx : 4;
      bus.out_ready_i = 1'b1;
      bus.in_valid_i  = (idx < 5);
      bus.data_i      = bd[sel];
      bus.round_i     = br[sel];
      #1;
      if (bus.out_valid_o) begin
        obs = {bus.data_o, bus.shift_o, bus.clamp_o};
        checks++;
        if (obs !== ex[got]) begin errors++; $display("FAIL bp_order beat=%0d got=%h want=%h", got, obs, ex[got]); end
        got++;
      end
      if (bus.in_valid_i && bus.in_ready_o) idx++;
      cyc++;
    end
    bus.in_valid_i = 1'b0;
    checks++;
    if (got !== 5) begin errors++; $display("FAIL bp_drain got=%0d beats want=5", got); end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL bp_dup cycle=%0d got=%b want=0", c, bus.out_valid_o); end
    end
  endtask

  task automatic test_flush();
    exp_t obs, want;
    int lat;
    logic [W-1:0] d;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      bus.out_ready_i = 1'b1;
      bus.in_valid_i  = 1'b1;
      bus.data_i      = rand_data();
      bus.round_i     = 1'b0;
      flush           = (c == 2);
    end
    @(negedge clk);
    flush          = 1'b0;
    bus.in_valid_i = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (c != 0) @(negedge clk);
      #1;
      checks++;
      if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL flush_valid cycle=%0d got=%b want=0", c, bus.out_valid_o); end
    end
    d = rand_data();
    want = model(d, 1'b1);
    send_one(d, 1'b1, obs, lat);
    checks++;
    if (lat !== 3 || obs !== want) begin errors++; $display("FAIL flush_recover lat=%0d got=%h want=%h", lat, obs, want); end
  endtask

  task automatic test_random();
    exp_t q [$];
    exp_t obs, want;
    int   sent, cyc;
    sent = 0;
    cyc  = 0;
    while ((sent < 200 || q.size() > 0) && cyc < 5000) begin
      @(negedge clk);
      bus.in_valid_i  = (sent < 200) && ($urandom_range(0, 3) != 0);
      bus.data_i      = rand_data();
      bus.round_i     = 1'($urandom_range(0, 1));
      bus.out_ready_i = ($urandom_range(0, 3) != 0);
      #1;
      if (bus.out_valid_o && bus.out_ready_i) begin
        obs = {bus.data_o, bus.shift_o, bus.clamp_o};
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL rand_extra got=%h want=none", obs);
        end else begin
          want = q.pop_front();
          if (obs !== want) begin errors++; $display("FAIL rand_beat got=%h want=%h", obs, want); end
        end
      end
      if (bus.in_valid_i && bus.in_ready_o) begin
        q.push_back(model(bus.data_i, bus.round_i));
        sent++;
      end
      cyc++;
    end
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b1;
    checks++;
    if (cyc >= 5000) begin errors++; $display("FAIL rand_timeout sent=%0d pending=%0d want=0", sent, q.size()); end
  endtask

  task automatic test_async_reset();
    exp_t obs, want;
    int lat;
    logic [W-1:0] d;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      bus.out_ready_i = 1'b1;
      bus.in_valid_i  = 1'b1;
      bus.data_i      = pack4(64'd1 << 40, 64'd1 << 10, 64'd99, 64'd3);
      bus.round_i     = 1'b0;
    end
    #1;
    checks++;
    if (bus.out_valid_o !== 1'b1) begin errors++; $display("FAIL arst_pre got=%b want=1", bus.out_valid_o); end
    #1;
    rst            = 1'b1;
    bus.in_valid_i = 1'b0;
    #1;
    checks++;
    if (bus.out_valid_o !== 1'b0 || bus.data_o !== '0) begin
      errors++; $display("FAIL arst_clear valid=%b data=%h want valid=0 data=0", bus.out_valid_o, bus.data_o);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    d = rand_data();
    want = model(d, 1'b0);
    send_one(d, 1'b0, obs, lat);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL arst_latency got=%0d want=3", lat); end
    checks++;
    if (obs !== want) begin errors++; $display("FAIL arst_beat got=%h want=%h", obs, want); end
  endtask

  initial begin
    bus.in_valid_i  = 1'b0;
    bus.round_i     = 1'b0;
    bus.data_i      = '0;
    bus.out_ready_i = 1'b1;
    test_reset();
    test_threshold();
    test_rounding();
    test_below();
    test_clamp();
    test_back_to_back();
    test_flush();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
